// File: rtl/tcp_hdr_tx.sv
// TCP header serializer: latches one header-field set, emits a 20-byte big-endian TCP header on an
// 8-bit stream, then forwards exactly (ip_len-40) payload bytes and pulses o_packet_done.
module tcp_hdr_tx #(
  parameter int unsigned MAX_PAYLOAD = 1460
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_src_port,
  input  logic [15:0] i_dst_port,
  input  logic [15:0] i_ip_len,
  input  logic [31:0] i_seq_number,
  input  logic [31:0] i_ack_number,
  input  logic [7:0]  i_flags,
  input  logic [15:0] i_window_size,
  input  logic        i_hdr_valid,
  output logic        o_packet_done,
  output logic        o_len_err,
  output logic        o_busy,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tkeep,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StPayload,
    StDone
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [15:0] len_q;
  logic [15:0] src_q;
  logic [15:0] dst_q;
  logic [31:0] seq_q;
  logic [31:0] ack_q;
  logic [7:0]  flags_q;
  logic [15:0] win_q;
  logic        err_seen_q;

  logic [15:0] len_raw;
  logic        len_bad;
  logic        last_beat;
  logic        m_hs;
  logic [7:0]  hdr_byte;

  assign len_raw   = i_ip_len - 16'd40;
  assign len_bad   = (i_ip_len < 16'd40) || ({16'd0, len_raw} > MAX_PAYLOAD);
  assign last_beat = (cnt_q == len_q - 16'd1);
  assign m_hs      = m_axis_tvalid && m_axis_tready;

  // Data offset 5 words, no options: byte 12 is always 0x50.
  always_comb begin
    hdr_byte = 8'h00;
    case (cnt_q)
      16'd0:   hdr_byte = src_q[15:8];
      16'd1:   hdr_byte = src_q[7:0];
      16'd2:   hdr_byte = dst_q[15:8];
      16'd3:   hdr_byte = dst_q[7:0];
      16'd4:   hdr_byte = seq_q[31:24];
      16'd5:   hdr_byte = seq_q[23:16];
      16'd6:   hdr_byte = seq_q[15:8];
      16'd7:   hdr_byte = seq_q[7:0];
      16'd8:   hdr_byte = ack_q[31:24];
      16'd9:   hdr_byte = ack_q[23:16];
      16'd10:  hdr_byte = ack_q[15:8];
      16'd11:  hdr_byte = ack_q[7:0];
      16'd12:  hdr_byte = 8'h50;
      16'd13:  hdr_byte = flags_q;
      16'd14:  hdr_byte = win_q[15:8];
      16'd15:  hdr_byte = win_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    m_axis_tdata  = 8'h00;
    m_axis_tkeep  = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    unique case (state_q)
      StHeader: begin
        m_axis_tdata  = hdr_byte;
        m_axis_tkeep  = 1'b1;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = (cnt_q == 16'd19) && (len_q == 16'd0);
      end
      StPayload: begin
        // The upstream tlast is not forwarded; the byte counter decides frame end.
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = last_beat;
        s_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= 16'd0;
      len_q         <= 16'd0;
      src_q         <= 16'd0;
      dst_q         <= 16'd0;
      seq_q         <= 32'd0;
      ack_q         <= 32'd0;
      flags_q       <= 8'd0;
      win_q         <= 16'd0;
      err_seen_q    <= 1'b0;
      o_packet_done <= 1'b0;
      o_len_err     <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      o_packet_done <= 1'b0;
      o_len_err     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_hdr_valid) begin
            src_q      <= i_src_port;
            dst_q      <= i_dst_port;
            seq_q      <= i_seq_number;
            ack_q      <= i_ack_number;
            flags_q    <= i_flags;
            win_q      <= i_window_size;
            len_q      <= len_bad ? 16'd0 : len_raw;
            o_len_err  <= len_bad;
            err_seen_q <= len_bad;
            cnt_q      <= 16'd0;
            o_busy     <= 1'b1;
            state_q    <= StHeader;
          end
        end
        StHeader: begin
          if (m_hs) begin
            if (cnt_q == 16'd19) begin
              cnt_q <= 16'd0;
              if (len_q == 16'd0) begin
                state_q       <= StDone;
                o_packet_done <= 1'b1;
              end else begin
                state_q <= StPayload;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        StPayload: begin
          if (m_hs) begin
            // Early tlast or missing tlast on the final byte: flag once per packet.
            if (!err_seen_q && (s_axis_tlast != last_beat)) begin
              o_len_err  <= 1'b1;
              err_seen_q <= 1'b1;
            end
            if (last_beat) begin
              cnt_q         <= 16'd0;
              state_q       <= StDone;
              o_packet_done <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        StDone: begin
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_hdr_tx.sv
// Bench for tcp_hdr_tx: a byte-queue frame model checked against every output beat, plus
// directed literal checks for SYN, payload, backpressure, length errors, reset and back-to-back.
module tb_tcp_hdr_tx;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] ip_len;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [7:0]  flags;
    logic [15:0] win;
  } hdr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] src_port, dst_port, ip_len, window_size;
  logic [31:0] seq_number, ack_number;
  logic [7:0]  flags;
  logic        hdr_valid;
  logic        packet_done, len_err, busy;
  logic [7:0]  s_tdata, m_tdata;
  logic        s_tkeep, s_tvalid, s_tready, s_tlast;
  logic        m_tkeep, m_tvalid, m_tready, m_tlast;

  always #5 clk = ~clk;

  tcp_hdr_tx #(.MAX_PAYLOAD(1460)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_src_port(src_port), .i_dst_port(dst_port), .i_ip_len(ip_len),
    .i_seq_number(seq_number), .i_ack_number(ack_number), .i_flags(flags),
    .i_window_size(window_size), .i_hdr_valid(hdr_valid),
    .o_packet_done(packet_done), .o_len_err(len_err), .o_busy(busy),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
  );

  int checks = 0, failures = 0;
  int done_cnt = 0, err_cnt = 0, cyc = 0, beats = 0;
  int last_beat_cyc = 0, done_cyc = 0;
  logic [7:0] exp_q[$];
  bit         exp_last_q[$];
  logic [7:0] got_q[$];
  bit         hold_v = 0;
  logic [7:0] hold_d;
  bit         bp_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Model: payload length from ip_len, header bytes from the field layout.
  function automatic int model_len(input logic [15:0] l);
    if (l < 16'd40) return 0;
    if (int'(l) - 40 > 1460) return 0;
    return int'(l) - 40;
  endfunction

  function automatic logic [7:0] model_hdr_byte(input hdr_t h, input int i);
    logic [159:0] v;
    v = {h.src, h.dst, h.seq, h.ack, 8'h50, h.flags, h.win, 32'h0};
    return v[159 - 8*i -: 8];
  endfunction

  task automatic push_model(input hdr_t h, input logic [7:0] pl[$]);
    int n = model_len(h.ip_len);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(model_hdr_byte(h, i));
      exp_last_q.push_back((i == 19) && (n == 0));
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pl[i]);
      exp_last_q.push_back(i == n - 1);
    end
  endtask

  // Compare process: every output handshake is checked against the model queue.
  initial forever begin
    logic [7:0] ed;
    bit el;
    @(negedge clk);
    cyc++;
    if (rst_n !== 1'b1) begin
      hold_v = 0;
    end else begin
      if (m_tvalid === 1'b1) begin
        check("busy_while_valid", busy, 1);
        if (hold_v) check("tdata_stable", m_tdata, hold_d);
        if (m_tready === 1'b1) begin
          got_q.push_back(m_tdata);
          beats++;
          last_beat_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_beat: got data 0x%0h, required no beat", m_tdata);
          end else begin
            ed = exp_q.pop_front();
            el = exp_last_q.pop_front();
            check("beat_data", m_tdata, ed);
            check("beat_last", m_tlast, el);
            check("beat_keep", m_tkeep, 1);
          end
          hold_v = 0;
        end else begin
          hold_v = 1;
          hold_d = m_tdata;
        end
      end else begin
        if (hold_v) check("tvalid_held", m_tvalid, 1);
        hold_v = 0;
      end
      if (packet_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (len_err === 1'b1) err_cnt++;
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) m_tready = ~m_tready;
      else m_tready = 1'b1;
    end
  end

  task automatic present(input hdr_t h);
    src_port = h.src; dst_port = h.dst; ip_len = h.ip_len;
    seq_number = h.seq; ack_number = h.ack; flags = h.flags; window_size = h.win;
    hdr_valid = 1'b1;
  endtask

  task automatic wait_done(input int d0, input string name);
    int g = 0;
    while (done_cnt == d0 && g < 4000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (done_cnt == d0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no packet_done after %0d cycles, required one", name, g);
    end
  endtask

  task automatic drive_payload(input logic [7:0] pl[$], input int n, input int tlast_at);
    for (int i = 0; i < n; i++) begin
      bit hs = 0;
      int g = 0;
      s_tdata = pl[i]; s_tkeep = 1'b1; s_tvalid = 1'b1; s_tlast = (i == tlast_at);
      while (!hs && g < 4000) begin
        @(negedge clk);
        hs = (s_tready === 1'b1);
        @(posedge clk);
        #1;
        g++;
      end
      if (!hs) begin
        checks++;
        failures++;
        $display("FAIL payload_timeout: byte %0d not accepted, required acceptance", i);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic run_packet(input string name, input hdr_t h, input logic [7:0] pl[$],
                            input int tlast_at, input int exp_err, input bit chk_lat);
    int d0 = done_cnt;
    int e0 = err_cnt;
    got_q.delete();
    push_model(h, pl);
    present(h);
    fork
      drive_payload(pl, model_len(h.ip_len), tlast_at);
      wait_done(d0, name);
      if (chk_lat) begin
        @(negedge clk);
        check({name, "_lat_idle"}, m_tvalid, 0);
        @(negedge clk);
        check({name, "_lat_valid"}, m_tvalid, 1);
        check({name, "_lat_byte0"}, m_tdata, h.src[15:8]);
      end
    join
    hdr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({name, "_done_count"}, done_cnt - d0, 1);
    check({name, "_len_err"}, err_cnt - e0, exp_err);
    check({name, "_model_drained"}, exp_q.size(), 0);
    check({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    hdr_t syn, dat, bpk, er1, er2, er3, big, rsth, b1, b2;
    logic [7:0] none[$];
    logic [7:0] pl4[$];
    logic [7:0] plbig[$];
    int d0, b0, g;

    syn  = '{src: 16'h1234, dst: 16'h0050, ip_len: 16'd40, seq: 32'h0, ack: 32'h0,
             flags: 8'h02, win: 16'h0001};
    dat  = '{src: 16'hC001, dst: 16'h01BB, ip_len: 16'd44, seq: 32'h11223344,
             ack: 32'h55667788, flags: 8'h18, win: 16'hFFFF};
    bpk  = '{src: 16'hA5A5, dst: 16'h5A5A, ip_len: 16'd44, seq: 32'hDEADBEEF,
             ack: 32'h01020304, flags: 8'h10, win: 16'h8000};
    er1  = '{src: 16'h0101, dst: 16'h0202, ip_len: 16'd44, seq: 32'h1, ack: 32'h2,
             flags: 8'h18, win: 16'h0400};
    er2  = '{src: 16'h0303, dst: 16'h0404, ip_len: 16'd30, seq: 32'h3, ack: 32'h4,
             flags: 8'h04, win: 16'h0010};
    er3  = '{src: 16'h0505, dst: 16'h0606, ip_len: 16'd1501, seq: 32'h5, ack: 32'h6,
             flags: 8'h10, win: 16'h0020};
    big  = '{src: 16'h0707, dst: 16'h0808, ip_len: 16'd1500, seq: 32'h7, ack: 32'h8,
             flags: 8'h18, win: 16'h0030};
    rsth = '{src: 16'h9ABC, dst: 16'hDEF0, ip_len: 16'd40, seq: 32'hCAFEF00D,
             ack: 32'h0BADF00D, flags: 8'h11, win: 16'h1111};
    b1   = '{src: 16'hAAAA, dst: 16'hBBBB, ip_len: 16'd40, seq: 32'h100, ack: 32'h200,
             flags: 8'h02, win: 16'h0100};
    b2   = '{src: 16'hCCCC, dst: 16'hDDDD, ip_len: 16'd40, seq: 32'h300, ack: 32'h400,
             flags: 8'h12, win: 16'h0200};
    pl4 = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 1460; i++) plbig.push_back(8'(i * 7 + 3));

    // Pin the model against hand-derived values.
    check("model_len_44", model_len(16'd44), 4);
    check("model_len_30", model_len(16'd30), 0);
    check("model_len_1501", model_len(16'd1501), 0);
    check("model_len_1500", model_len(16'd1500), 1460);
    check("model_syn_b0", model_hdr_byte(syn, 0), 8'h12);
    check("model_syn_b13", model_hdr_byte(syn, 13), 8'h02);

    rst_n = 1'b0; hdr_valid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = 1'b0;
    s_tdata = 8'h00; present(syn); hdr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_done", packet_done, 0);
    check("rst_len_err", len_err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_packet("syn", syn, none, -1, 0, 1'b1);
    check("syn_beats", got_q.size(), 20);
    check("syn_byte12", got_q[12], 8'h50);
    check("syn_byte13", got_q[13], 8'h02);
    check("syn_done_latency", done_cyc - last_beat_cyc, 1);

    run_packet("data", dat, pl4, 3, 0, 1'b0);
    check("data_beats", got_q.size(), 24);
    check("data_b20", got_q[20], 8'hDE);
    check("data_b21", got_q[21], 8'hAD);
    check("data_b22", got_q[22], 8'hBE);
    check("data_b23", got_q[23], 8'hEF);

    bp_en = 1;
    run_packet("bp", bpk, pl4, 3, 0, 1'b0);
    check("bp_beats", got_q.size(), 24);
    check("bp_b4", got_q[4], 8'hDE);
    bp_en = 0;

    run_packet("early_tlast", er1, pl4, 1, 1, 1'b0);
    check("early_tlast_beats", got_q.size(), 24);
    run_packet("short_len", er2, none, -1, 1, 1'b0);
    check("short_len_beats", got_q.size(), 20);
    run_packet("over_max", er3, none, -1, 1, 1'b0);
    check("over_max_beats", got_q.size(), 20);
    run_packet("max_payload", big, plbig, 1459, 0, 1'b0);
    check("max_payload_beats", got_q.size(), 1480);

    // Reset while header byte 7 is on the bus.
    d0 = done_cnt;
    b0 = beats;
    g = 0;
    push_model(rsth, none);
    present(rsth);
    while (beats < b0 + 7 && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("rst_mid_reached_b7", beats - b0, 7);
    rst_n = 1'b0;
    hdr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_tvalid", m_tvalid, 0);
    check("rst_mid_busy", busy, 0);
    exp_q.delete();
    exp_last_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_no_done", done_cnt - d0, 0);
    run_packet("reissue", rsth, none, -1, 0, 1'b0);
    check("reissue_beats", got_q.size(), 20);
    check("reissue_b0", got_q[0], 8'h9A);
    check("reissue_b7", got_q[7], 8'h0D);

    // Back-to-back: valid stays high through DONE with old fields, new fields follow.
    d0 = done_cnt;
    got_q.delete();
    push_model(b1, none);
    push_model(b2, none);
    present(b1);
    wait_done(d0, "b2b_first");
    present(b2);
    wait_done(d0 + 1, "b2b_second");
    hdr_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("b2b_done_count", done_cnt - d0, 2);
    check("b2b_beats", got_q.size(), 40);
    check("b2b_second_b0", got_q[20], 8'hCC);
    check("b2b_model_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
